wb_csr_counters: RTL and testbench

// - Write-back-stage machine counter unit: holds 64-bit mcycle and minstret.
// - Consumes the registered CSR write (csr_we/waddr/wdata) and instret_incr from the mem/wb pipeline register.
// - Serves combinational CSR reads to the execute stage for M-mode and user read-only shadow addresses.

---
 rtl/wb_csr_counters.sv | 162 ++++++++++++++++
 tb/tb_wb_csr_counters.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_csr_counters.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wb_csr_counters                                              |
// | Description : Write-back-stage mcycle/minstret counter unit with           |
// |               combinational CSR read port and user read-only shadows.      |
// |               Optional mcountinhibit: define WB_CSR_COUNTERS_INHIBIT_EN.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module wb_csr_counters #(
    parameter int CNT_WIDTH = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 csr_we_i,
    input  logic [31:0]          csr_waddr_i,
    input  logic [31:0]          csr_wdata_i,
    input  logic                 instret_incr_i,
    input  logic [31:0]          csr_raddr_i,
    output logic [31:0]          csr_rdata_o,
    output logic                 csr_rhit_o,
    output logic [CNT_WIDTH-1:0] cycle_o,
    output logic [CNT_WIDTH-1:0] instret_o
);

    localparam int c_HI_W = CNT_WIDTH - 32;

    localparam logic [11:0] c_ADDR_MCYCLE        = 12'hB00;
    localparam logic [11:0] c_ADDR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] c_ADDR_MINSTRET      = 12'hB02;
    localparam logic [11:0] c_ADDR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] c_ADDR_CYCLE         = 12'hC00;
    localparam logic [11:0] c_ADDR_CYCLEH        = 12'hC80;
    localparam logic [11:0] c_ADDR_INSTRET       = 12'hC02;
    localparam logic [11:0] c_ADDR_INSTRETH      = 12'hC82;
`ifdef WB_CSR_COUNTERS_INHIBIT_EN
    localparam logic [11:0] c_ADDR_MCOUNTINHIBIT = 12'h320;
`endif

    localparam logic [CNT_WIDTH-1:0] c_ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] r_mcycle;
    logic [CNT_WIDTH-1:0] r_minstret;

    logic [11:0] w_waddr;
    logic [11:0] w_raddr;
    logic        w_wr_mcycle_lo;
    logic        w_wr_mcycle_hi;
    logic        w_wr_minstret_lo;
    logic        w_wr_minstret_hi;
    logic        w_inhibit_cy;
    logic        w_inhibit_ir;
    logic [31:0] w_mcycle_hi;
    logic [31:0] w_minstret_hi;
    logic [31:0] w_rdata;
    logic        w_rhit;
    logic        w_unused;

    assign w_waddr = csr_waddr_i[11:0];
    assign w_raddr = csr_raddr_i[11:0];

    // Only the M-mode addresses are writable; Cxx shadows fall through to no-op.
    assign w_wr_mcycle_lo   = csr_we_i && (w_waddr == c_ADDR_MCYCLE);
    assign w_wr_mcycle_hi   = csr_we_i && (w_waddr == c_ADDR_MCYCLEH);
    assign w_wr_minstret_lo = csr_we_i && (w_waddr == c_ADDR_MINSTRET);
    assign w_wr_minstret_hi = csr_we_i && (w_waddr == c_ADDR_MINSTRETH);

`ifdef WB_CSR_COUNTERS_INHIBIT_EN
    logic r_inhibit_cy;
    logic r_inhibit_ir;
    logic w_wr_inhibit;

    assign w_wr_inhibit = csr_we_i && (w_waddr == c_ADDR_MCOUNTINHIBIT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_inhibit_cy <= 1'b0;
            r_inhibit_ir <= 1'b0;
        end else if (w_wr_inhibit) begin
            r_inhibit_cy <= csr_wdata_i[0];
            r_inhibit_ir <= csr_wdata_i[2];
        end
    end

    assign w_inhibit_cy = r_inhibit_cy;
    assign w_inhibit_ir = r_inhibit_ir;
`else
    assign w_inhibit_cy = 1'b0;
    assign w_inhibit_ir = 1'b0;
`endif

    // A write replaces the increment for that cycle; the other half is held.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mcycle <= '0;
        end else if (w_wr_mcycle_lo) begin
            r_mcycle <= {r_mcycle[CNT_WIDTH-1:32], csr_wdata_i};
        end else if (w_wr_mcycle_hi) begin
            r_mcycle <= {csr_wdata_i[c_HI_W-1:0], r_mcycle[31:0]};
        end else if (!w_inhibit_cy) begin
            r_mcycle <= r_mcycle + c_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_minstret <= '0;
        end else if (w_wr_minstret_lo) begin
            r_minstret <= {r_minstret[CNT_WIDTH-1:32], csr_wdata_i};
        end else if (w_wr_minstret_hi) begin
            r_minstret <= {csr_wdata_i[c_HI_W-1:0], r_minstret[31:0]};
        end else if (instret_incr_i && !w_inhibit_ir) begin
            r_minstret <= r_minstret + c_ONE;
        end
    end

    assign w_mcycle_hi   = 32'(r_mcycle[CNT_WIDTH-1:32]);
    assign w_minstret_hi = 32'(r_minstret[CNT_WIDTH-1:32]);

    // Reads see the registered state only; same-cycle writes are not forwarded.
    always_comb begin
        w_rdata = 32'h0;
        w_rhit  = 1'b0;
        case (w_raddr)
            c_ADDR_MCYCLE, c_ADDR_CYCLE: begin
                w_rhit  = 1'b1;
                w_rdata = r_mcycle[31:0];
            end
            c_ADDR_MCYCLEH, c_ADDR_CYCLEH: begin
                w_rhit  = 1'b1;
                w_rdata = w_mcycle_hi;
            end
            c_ADDR_MINSTRET, c_ADDR_INSTRET: begin
                w_rhit  = 1'b1;
                w_rdata = r_minstret[31:0];
            end
            c_ADDR_MINSTRETH, c_ADDR_INSTRETH: begin
                w_rhit  = 1'b1;
                w_rdata = w_minstret_hi;
            end
`ifdef WB_CSR_COUNTERS_INHIBIT_EN
            c_ADDR_MCOUNTINHIBIT: begin
                w_rhit  = 1'b1;
                w_rdata = {29'h0, r_inhibit_ir, 1'b0, r_inhibit_cy};
            end
`endif
            default: begin
                w_rhit  = 1'b0;
                w_rdata = 32'h0;
            end
        endcase
    end

    assign csr_rdata_o = w_rdata;
    assign csr_rhit_o  = w_rhit;
    assign cycle_o     = r_mcycle;
    assign instret_o   = r_minstret;

    // Address bits above [11:0] are intentionally ignored.
    assign w_unused = &{1'b0, csr_waddr_i[31:12], csr_raddr_i[31:12]};

endmodule
`default_nettype wire

// File: tb/tb_wb_csr_counters.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_wb_csr_counters                                           |
// | Description : Scoreboard testbench for wb_csr_counters (CNT_WIDTH = 64).   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_wb_csr_counters;

`ifdef WB_CSR_COUNTERS_INHIBIT_EN
    localparam bit c_INH = 1'b1;
`else
    localparam bit c_INH = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        csr_we_i;
    logic [31:0] csr_waddr_i;
    logic [31:0] csr_wdata_i;
    logic        instret_incr_i;
    logic [31:0] csr_raddr_i;
    logic [31:0] csr_rdata_o;
    logic        csr_rhit_o;
    logic [63:0] cycle_o;
    logic [63:0] instret_o;

    int n_vec  = 0;
    int n_miss = 0;

    string       tag_q[$];
    logic [63:0] exp_q[$];

    logic [63:0] m_cyc = '0;
    logic [63:0] m_ins = '0;
    logic [1:0]  m_inh = '0;

    always #5 clk_i = ~clk_i;

    wb_csr_counters #(.CNT_WIDTH(64)) u_dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .csr_we_i       (csr_we_i),
        .csr_waddr_i    (csr_waddr_i),
        .csr_wdata_i    (csr_wdata_i),
        .instret_incr_i (instret_incr_i),
        .csr_raddr_i    (csr_raddr_i),
        .csr_rdata_o    (csr_rdata_o),
        .csr_rhit_o     (csr_rhit_o),
        .cycle_o        (cycle_o),
        .instret_o      (instret_o)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [63:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic sb_pop(input logic [63:0] obs);
        string       t;
        logic [63:0] e;
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        check_val(t, obs, e);
    endtask

    // Reference model advances on the inputs currently driven, then the edge is taken.
    task automatic tick();
        logic [63:0] nc;
        logic [63:0] ni;
        logic [1:0]  nh;
        logic [11:0] wa;
        wa = csr_waddr_i[11:0];
        nc = m_cyc;
        ni = m_ins;
        nh = m_inh;
        if (rst_i) begin
            nc = '0;
            ni = '0;
            nh = '0;
        end else begin
            if (csr_we_i && wa == 12'hB00)      nc[31:0]  = csr_wdata_i;
            else if (csr_we_i && wa == 12'hB80) nc[63:32] = csr_wdata_i;
            else if (!m_inh[0])                 nc = m_cyc + 64'd1;
            if (csr_we_i && wa == 12'hB02)      ni[31:0]  = csr_wdata_i;
            else if (csr_we_i && wa == 12'hB82) ni[63:32] = csr_wdata_i;
            else if (instret_incr_i && !m_inh[1]) ni = m_ins + 64'd1;
            if (c_INH && csr_we_i && wa == 12'h320) nh = {csr_wdata_i[2], csr_wdata_i[0]};
        end
        sb_push("cycle_o", nc);
        sb_push("instret_o", ni);
        @(posedge clk_i);
        #1;
        m_cyc = nc;
        m_ins = ni;
        m_inh = nh;
        sb_pop(cycle_o);
        sb_pop(instret_o);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        csr_we_i    = 1'b1;
        csr_waddr_i = addr;
        csr_wdata_i = data;
        tick();
        csr_we_i    = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                      input logic exp_hit);
        csr_raddr_i = addr;
        sb_push({tag, "_rdata"}, {32'h0, exp_data});
        sb_push({tag, "_rhit"}, {63'h0, exp_hit});
        #1;
        sb_pop({32'h0, csr_rdata_o});
        sb_pop({63'h0, csr_rhit_o});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] s_c;
        logic [63:0] s_i;
        rst_i          = 1'b1;
        csr_we_i       = 1'b0;
        csr_waddr_i    = '0;
        csr_wdata_i    = '0;
        instret_incr_i = 1'b0;
        csr_raddr_i    = '0;

        // Reset and idle count
        repeat (3) tick();
        rd("rst_rd0", 32'h0, 32'h0, 1'b0);
        rst_i = 1'b0;
        repeat (10) tick();
        check_val("idle_cycle", cycle_o, 64'd10);
        check_val("idle_instret", instret_o, 64'd0);
        rd("rd_C00", 32'hC00, 32'd10, 1'b1);
        rd("rd_C80", 32'hC80, 32'd0, 1'b1);

        // Retire stream with a low-half write on the third beat
        instret_incr_i = 1'b1;
        tick();
        tick();
        csr_we_i    = 1'b1;
        csr_waddr_i = 32'hB02;
        csr_wdata_i = 32'h100;
        rd("raw_B02", 32'hB02, 32'd2, 1'b1);
        tick();
        csr_we_i = 1'b0;
        tick();
        tick();
        instret_incr_i = 1'b0;
        check_val("incr_wr_instret", instret_o, 64'h102);
        rd("rd_C02", 32'hC02, 32'h102, 1'b1);

        // Low-half carry into high half
        wr(32'hB00, 32'hFFFF_FFFF);
        wr(32'hB80, 32'h0);
        tick();
        tick();
        check_val("carry_cycle", cycle_o, 64'h1_0000_0001);
        rd("rd_B80", 32'hB80, 32'h1, 1'b1);
        rd("rd_B00", 32'hB00, m_cyc[31:0], 1'b1);

        // Read-only shadows, unmapped and upper address bits
        wr(32'hC02, 32'h55);
        wr(32'h7A0, 32'h55);
        wr(32'hFFFF_FC82, 32'h55);
        check_val("ro_instret", instret_o, 64'h102);
        rd("rd_7A0", 32'h7A0, 32'h0, 1'b0);
        rd("rd_hiaddr", 32'h1234_5C02, 32'h102, 1'b1);
        wr(32'hABCD_EB02, 32'h7);
        check_val("hiaddr_wr", instret_o, 64'h7);
        wr(32'hB82, 32'hDEAD_0001);
        check_val("wr_B82", instret_o, 64'hDEAD_0001_0000_0007);

        // Full wrap of mcycle
        wr(32'hB80, 32'hFFFF_FFFF);
        wr(32'hB00, 32'hFFFF_FFFE);
        tick();
        tick();
        check_val("wrap_cycle", cycle_o, 64'h0);
        rd("rd_B80_wrap", 32'hB80, 32'h0, 1'b1);

`ifdef WB_CSR_COUNTERS_INHIBIT_EN
        instret_incr_i = 1'b1;
        wr(32'h320, 32'h5);
        s_c = m_cyc;
        s_i = m_ins;
        repeat (4) tick();
        check_val("inh_cyc_frozen", cycle_o, s_c);
        check_val("inh_ins_frozen", instret_o, s_i);
        rd("rd_320", 32'h320, 32'h5, 1'b1);
        wr(32'hB02, 32'h33);
        check_val("inh_wr_frozen", instret_o, {s_i[63:32], 32'h33});
        wr(32'h320, 32'h0);
        check_val("inh_clr_edge", cycle_o, s_c);
        tick();
        check_val("inh_resume_cyc", cycle_o, s_c + 64'd1);
        check_val("inh_resume_ins", instret_o, {s_i[63:32], 32'h34});
        instret_incr_i = 1'b0;
`else
        s_c = m_cyc;
        s_i = m_ins;
        wr(32'h320, 32'h5);
        tick();
        tick();
        check_val("noinh_cycle", cycle_o, s_c + 64'd3);
        check_val("noinh_instret", instret_o, s_i);
        rd("rd_320", 32'h320, 32'h0, 1'b0);
`endif

        // Reset mid-count beats write and increment
        rst_i          = 1'b1;
        csr_we_i       = 1'b1;
        csr_waddr_i    = 32'hB00;
        csr_wdata_i    = 32'h1234;
        instret_incr_i = 1'b1;
        tick();
        check_val("rst_mid_cycle", cycle_o, 64'h0);
        check_val("rst_mid_instret", instret_o, 64'h0);
        rst_i    = 1'b0;
        csr_we_i = 1'b0;
        tick();
        check_val("post_rst_cycle", cycle_o, 64'h1);
        check_val("post_rst_instret", instret_o, 64'h1);
        instret_incr_i = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
